// File: rtl/rackbus_align_pkg.sv
// Shared types, constants and parameter-legality helpers for the rackbus
// word-alignment controller.
package rackbus_align_pkg;

  localparam int WORD_W = 12;
  localparam int CNT_W  = 8;

  localparam logic [WORD_W-1:0] DEFAULT_TRAIN_PATTERN = 12'hA5C;

  // Per-lane alignment state.
  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    FAIL
  } lane_state_t;

  // A training word must differ from every nonzero rotation of itself,
  // otherwise a slipped lane could lock on the wrong bit boundary.
  function automatic bit pattern_ok(input logic [WORD_W-1:0] pat);
    logic [2*WORD_W-1:0] dbl;
    pattern_ok = 1'b1;
    dbl        = {pat, pat};
    for (int r = 1; r < WORD_W; r++) begin
      if (dbl[2*WORD_W-1-r -: WORD_W] == pat) pattern_ok = 1'b0;
    end
  endfunction

  function automatic bit count_ok(input int val, input int lo);
    return (val >= lo) && (val <= 255);
  endfunction

  // Counters are 8 bits and compared for equality, so every count must
  // fit in 8 bits and be nonzero.
  function automatic bit params_legal(input int                ngroups,
                                      input logic [WORD_W-1:0] pat,
                                      input int                lock_count,
                                      input int                unlock_count,
                                      input int                slip_wait,
                                      input int                max_slips);
    return (ngroups >= 1) && pattern_ok(pat) &&
           count_ok(lock_count, 2) && count_ok(unlock_count, 1) &&
           count_ok(slip_wait, 1) && count_ok(max_slips, 1);
  endfunction

endpackage

// File: rtl/rackbus_align_lane.sv
// One lane of the alignment controller: searches for the training word,
// requests bitslips until locked, then monitors lock while training is on.
module rackbus_align_lane
  import rackbus_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int                LOCK_COUNT    = 16,
  parameter int                UNLOCK_COUNT  = 4,
  parameter int                SLIP_WAIT     = 8,
  parameter int                MAX_SLIPS     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe_i,
  input  logic              train_en_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              bitslip_o,
  output logic              locked_o,
  output logic              fail_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam logic [CNT_W-1:0] LOCK_CNT   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_CNT = CNT_W'(UNLOCK_COUNT);
  localparam logic [CNT_W-1:0] WAIT_CNT   = CNT_W'(SLIP_WAIT);
  localparam logic [CNT_W-1:0] SLIP_MAX   = CNT_W'(MAX_SLIPS);
  localparam logic [CNT_W-1:0] ERR_SAT    = '1;

  lane_state_t      state_q, state_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             bitslip_q, bitslip_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic             is_match;

  assign is_match = (word_i == TRAIN_PATTERN);

  // Next-state, counter and registered-output logic for the lane FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; a missed assignment here would infer a latch.
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (train_en_i) state_d = CHECK;
      end
      CHECK: begin
        // Dropping training wins over a strobe in the same cycle.
        if (!train_en_i) begin
          state_d = IDLE;
        end else if (strobe_i) begin
          if (is_match) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_d == LOCK_CNT) begin
              state_d   = LOCKED;
              bad_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
            state_d     = (slip_cnt_q == SLIP_MAX) ? FAIL : SLIP;
          end
        end
      end
      SLIP: begin
        if (!train_en_i) begin
          state_d = IDLE;
        end else begin
          slip_cnt_d = slip_cnt_q + 1'b1;
          wait_cnt_d = WAIT_CNT;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Strobes here carry words still refilling the deserializer.
        if (!train_en_i) begin
          state_d = IDLE;
        end else if (strobe_i) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_q == 8'd1) begin
            state_d     = CHECK;
            match_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        // With training off the lane carries payload, so no comparison.
        if (train_en_i && strobe_i) begin
          if (is_match) begin
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + 1'b1;
            if (err_cnt_q != ERR_SAT) err_cnt_d = err_cnt_q + 1'b1;
            if (bad_cnt_d == UNLOCK_CNT) begin
              state_d     = CHECK;
              match_cnt_d = '0;
              slip_cnt_d  = '0;
              bad_cnt_d   = '0;
            end
          end
        end
      end
      FAIL: begin
        if (!train_en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Sitting in or returning to IDLE leaves every counter clear, so a
    // fresh training run always starts from zero.
    if (state_d == IDLE) begin
      match_cnt_d = '0;
      slip_cnt_d  = '0;
      wait_cnt_d  = '0;
      bad_cnt_d   = '0;
      err_cnt_d   = '0;
    end

    bitslip_d = (state_d == SLIP);
    locked_d  = (state_d == LOCKED);
    fail_d    = (state_d == FAIL);
  end

  // State, counter and output registers; reset drops any pending slip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      match_cnt_q <= '0;
      slip_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      err_cnt_q   <= '0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_cnt_q   <= err_cnt_d;
      bitslip_q   <= bitslip_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = locked_q;
  assign fail_o    = fail_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/rackbus_align.sv
// Word-alignment controller for the rackbus input path: one independent
// alignment FSM per 12-bit lane behind the 4:3 gearbox.
module rackbus_align
  import rackbus_align_pkg::*;
#(
  parameter int                NGROUPS       = 2,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int                LOCK_COUNT    = 16,
  parameter int                UNLOCK_COUNT  = 4,
  parameter int                SLIP_WAIT     = 8,
  parameter int                MAX_SLIPS     = 12
) (
  input  logic                      fast_clk,
  input  logic                      fast_rst_n,
  input  logic [3:0]                fast_phase_i,
  input  logic [NGROUPS*WORD_W-1:0] fast_par_i,
  input  logic                      train_en_i,
  output logic [NGROUPS-1:0]        bitslip_o,
  output logic [NGROUPS-1:0]        lane_locked_o,
  output logic                      all_locked_o,
  output logic [NGROUPS-1:0]        align_fail_o,
  output logic [NGROUPS*CNT_W-1:0]  err_cnt_o
);

  if (!params_legal(NGROUPS, TRAIN_PATTERN, LOCK_COUNT, UNLOCK_COUNT,
                    SLIP_WAIT, MAX_SLIPS)) begin : g_bad_params
    $error("rackbus_align: illegal parameter set");
  end

  // A new gearbox word is valid on phase 2; the other phases are unused.
  logic word_strobe;
  logic unused_phase;

  assign word_strobe  = fast_phase_i[2];
  assign unused_phase = ^{fast_phase_i[3], fast_phase_i[1:0]};

  for (genvar g = 0; g < NGROUPS; g++) begin : g_lane
    rackbus_align_lane #(
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_COUNT    (LOCK_COUNT),
      .UNLOCK_COUNT  (UNLOCK_COUNT),
      .SLIP_WAIT     (SLIP_WAIT),
      .MAX_SLIPS     (MAX_SLIPS)
    ) u_lane (
      .clk        (fast_clk),
      .rst_n      (fast_rst_n),
      .strobe_i   (word_strobe),
      .train_en_i (train_en_i),
      .word_i     (fast_par_i[WORD_W*g +: WORD_W]),
      .bitslip_o  (bitslip_o[g]),
      .locked_o   (lane_locked_o[g]),
      .fail_o     (align_fail_o[g]),
      .err_cnt_o  (err_cnt_o[CNT_W*g +: CNT_W])
    );
  end

  assign all_locked_o = &lane_locked_o;

endmodule

// File: tb/tb_rackbus_align.sv
// Directed bench for rackbus_align: a small deserializer model rotates each
// lane's word on every bitslip pulse; expected values are hand-computed.
module tb_rackbus_align;

  localparam logic [11:0] TRAIN = 12'hA5C;

  logic        fast_clk = 1'b0;
  logic        fast_rst_n;
  logic [3:0]  fast_phase_i;
  logic [23:0] fast_par_i;
  logic        train_en_i;
  logic [1:0]  bitslip_o;
  logic [1:0]  lane_locked_o;
  logic        all_locked_o;
  logic [1:0]  align_fail_o;
  logic [15:0] err_cnt_o;

  rackbus_align dut (
    .fast_clk      (fast_clk),
    .fast_rst_n    (fast_rst_n),
    .fast_phase_i  (fast_phase_i),
    .fast_par_i    (fast_par_i),
    .train_en_i    (train_en_i),
    .bitslip_o     (bitslip_o),
    .lane_locked_o (lane_locked_o),
    .all_locked_o  (all_locked_o),
    .align_fail_o  (align_fail_o),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 fast_clk = ~fast_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          strobe_cnt = 0;
  int          phase_idx = 0;
  int          base;
  int          offset[2];
  bit          const_mode[2];
  logic [11:0] const_word[2];
  int          slip_seen[2];
  int          last_slip[2];
  int          min_gap[2];
  int          lock_rise[2];
  bit          lock_rise_on_strobe[2];
  int          fail_rise[2];
  int          long_pulse;
  logic [1:0]  prev_slip, prev_locked, prev_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rotl12(input logic [11:0] w, input int k);
    logic [23:0] d;
    d = {w, w};
    return d[23-k -: 12];
  endfunction

  task automatic drive_par();
    for (int g = 0; g < 2; g++)
      fast_par_i[12*g +: 12] = const_mode[g] ? const_word[g] : rotl12(TRAIN, offset[g]);
  endtask

  // One clock: advance, sample #1 after the edge, update the models, drive.
  task automatic step();
    bit was_strobe;
    was_strobe = fast_phase_i[2];
    @(posedge fast_clk);
    #1;
    if (was_strobe) strobe_cnt++;
    for (int g = 0; g < 2; g++) begin
      if (bitslip_o[g]) begin
        if (prev_slip[g]) begin
          long_pulse++;
        end else begin
          if (slip_seen[g] > 0 && (strobe_cnt - last_slip[g]) < min_gap[g])
            min_gap[g] = strobe_cnt - last_slip[g];
          slip_seen[g]++;
          last_slip[g] = strobe_cnt;
          offset[g]    = (offset[g] + 11) % 12;
        end
      end
      if (lane_locked_o[g] && !prev_locked[g]) begin
        lock_rise[g]           = strobe_cnt;
        lock_rise_on_strobe[g] = was_strobe;
      end
      if (align_fail_o[g] && !prev_fail[g]) fail_rise[g] = strobe_cnt;
    end
    prev_slip    = bitslip_o;
    prev_locked  = lane_locked_o;
    prev_fail    = align_fail_o;
    phase_idx    = (phase_idx + 1) % 4;
    fast_phase_i = 4'b0001 << phase_idx;
    drive_par();
  endtask

  // Returns #1 after the n-th following strobe edge.
  task automatic wait_strobes(input int n);
    int target;
    target = strobe_cnt + n;
    for (int i = 0; i < 4*n + 8 && strobe_cnt < target; i++) step();
  endtask

  task automatic clear_tally();
    for (int g = 0; g < 2; g++) begin
      slip_seen[g] = 0;
      last_slip[g] = 0;
      min_gap[g]   = 1000;
      lock_rise[g] = -1;
      fail_rise[g] = -1;
      lock_rise_on_strobe[g] = 1'b0;
    end
    long_pulse = 0;
  endtask

  task automatic apply_reset();
    fast_rst_n = 1'b0;
    train_en_i = 1'b0;
    for (int g = 0; g < 2; g++) begin
      offset[g]     = 0;
      const_mode[g] = 1'b0;
      const_word[g] = 12'h000;
    end
    drive_par();
    repeat (3) step();
    fast_rst_n = 1'b1;
    step();
    clear_tally();
  endtask

  task automatic start_training();
    train_en_i = 1'b1;
    step();
    base = strobe_cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fast_rst_n   = 1'b0;
    fast_phase_i = 4'b0001;
    fast_par_i   = '0;
    train_en_i   = 1'b0;
    prev_slip    = '0;
    prev_locked  = '0;
    prev_fail    = '0;

    // Reset state
    apply_reset();
    check("reset_bitslip", 32'(bitslip_o), 32'h0);
    check("reset_locked", 32'({all_locked_o, lane_locked_o}), 32'h0);
    check("reset_fail", 32'(align_fail_o), 32'h0);
    check("reset_err", 32'(err_cnt_o), 32'h0);

    // Aligned start: lock exactly on the 16th matching strobe, no slips
    start_training();
    wait_strobes(15);
    check("aligned_not_yet", 32'(lane_locked_o), 32'h0);
    wait_strobes(1);
    check("aligned_locked", 32'({all_locked_o, lane_locked_o}), 32'h7);
    check("aligned_rise_strobe", 32'(lock_rise[0] - base), 32'd16);
    check("aligned_rise_edge", 32'(lock_rise_on_strobe[1]), 32'h1);
    check("aligned_no_slips", 32'(slip_seen[0] + slip_seen[1]), 32'h0);

    // Lane 0 misaligned by 3 bits, lane 1 aligned
    apply_reset();
    offset[0] = 3;
    drive_par();
    start_training();
    wait_strobes(16);
    check("mis_lane1_locked", 32'(lane_locked_o), 32'h2);
    wait_strobes(27);
    check("mis_all_locked", 32'({all_locked_o, lane_locked_o}), 32'h7);
    check("mis_lane0_rise", 32'(lock_rise[0] - base), 32'd43);
    check("mis_slip_count", 32'(slip_seen[0]), 32'd3);
    check("mis_lane1_slips", 32'(slip_seen[1]), 32'd0);
    check("mis_slip_gap", 32'(min_gap[0]), 32'd9);
    check("mis_pulse_width", 32'(long_pulse), 32'd0);

    // Never-matching data: 12 slips then FAIL
    apply_reset();
    const_mode[0] = 1'b1;
    const_mode[1] = 1'b1;
    drive_par();
    start_training();
    wait_strobes(108);
    check("nomatch_fail_early", 32'(align_fail_o), 32'h0);
    check("nomatch_slips", 32'(slip_seen[0]), 32'd12);
    wait_strobes(1);
    check("nomatch_fail", 32'(align_fail_o), 32'h3);
    check("nomatch_fail_strobe", 32'(fail_rise[1] - base), 32'd109);
    wait_strobes(10);
    check("nomatch_hold_slips", 32'(slip_seen[0] + slip_seen[1]), 32'd24);
    check("nomatch_hold_fail", 32'(align_fail_o), 32'h3);
    train_en_i = 1'b0;
    step();
    check("nomatch_idle", 32'({bitslip_o, lane_locked_o, align_fail_o, err_cnt_o}), 32'h0);

    // Locked lanes: error counting and loss of lock
    apply_reset();
    start_training();
    wait_strobes(16);
    check("lk_locked", 32'(lane_locked_o), 32'h3);
    const_mode[0] = 1'b1;
    drive_par();
    wait_strobes(1);
    check("lk_err_first", 32'(err_cnt_o), 32'h0001);
    wait_strobes(2);
    const_mode[0] = 1'b0;
    drive_par();
    wait_strobes(1);
    check("lk_3bad_held", 32'(lane_locked_o), 32'h3);
    check("lk_3bad_err", 32'(err_cnt_o), 32'h0003);
    const_mode[0] = 1'b1;
    drive_par();
    wait_strobes(3);
    check("lk_3more_held", 32'(lane_locked_o), 32'h3);
    wait_strobes(1);
    check("lk_unlock", 32'({all_locked_o, lane_locked_o}), 32'h2);
    check("lk_unlock_err", 32'(err_cnt_o), 32'h0007);
    check("lk_unlock_noslip", 32'(slip_seen[0]), 32'd0);
    wait_strobes(1);
    check("lk_relock_slip", 32'(bitslip_o), 32'h1);

    // Error counter saturation on lane 1 (alternate bad/good keeps lock)
    apply_reset();
    start_training();
    wait_strobes(16);
    for (int i = 0; i < 256; i++) begin
      if (i == 254) check("sat_254", 32'(err_cnt_o), 32'hFE00);
      const_mode[1] = 1'b1;
      drive_par();
      wait_strobes(1);
      const_mode[1] = 1'b0;
      drive_par();
      wait_strobes(1);
    end
    check("sat_255", 32'(err_cnt_o), 32'hFF00);
    check("sat_locked", 32'(lane_locked_o), 32'h3);

    // Asynchronous reset while lane 0 waits and lane 1 is locked
    apply_reset();
    offset[0] = 3;
    drive_par();
    start_training();
    wait_strobes(16);
    step();
    check("rst_pre_locked", 32'(lane_locked_o), 32'h2);
    #3;
    fast_rst_n = 1'b0;
    #1;
    check("rst_async_out", 32'({all_locked_o, bitslip_o, lane_locked_o, align_fail_o, err_cnt_o}), 32'h0);

    // Asynchronous reset during a bitslip pulse drops it at once
    apply_reset();
    offset[0] = 3;
    drive_par();
    start_training();
    wait_strobes(1);
    check("rst_slip_pre", 32'(bitslip_o), 32'h1);
    #3;
    fast_rst_n = 1'b0;
    #1;
    check("rst_slip_dropped", 32'(bitslip_o), 32'h0);

    // Abort on the same edge as a mismatching strobe in CHECK
    apply_reset();
    offset[0] = 3;
    drive_par();
    start_training();
    for (int i = 0; i < 4 && !fast_phase_i[2]; i++) step();
    train_en_i = 1'b0;
    step();
    check("abort_no_slip", 32'(bitslip_o), 32'h0);
    repeat (6) step();
    check("abort_slip_count", 32'(slip_seen[0]), 32'd0);
    check("abort_idle", 32'({bitslip_o, lane_locked_o, align_fail_o, err_cnt_o}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
